// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive path
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } state_t;

    localparam int DATA_BITS = 8;

    // Mid-bit offset used to confirm the start bit at its centre.
    function automatic int half_bit(input int clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the raw serial line, idles high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset to the idle-high line level so no false start bit appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive state machine: start confirm, 8 data bits, stop check
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_serial,
    output logic        rx_dv,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic [2:0]  sm_state,
    output logic [15:0] clock_count,
    output logic        busy
);

    localparam logic [15:0] LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF     = 16'(half_bit(CLKS_PER_BIT));
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state;
    logic [2:0] bit_idx;
    logic       rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    // Frame sequencing with the bit-period counter kept inline: START counts to
    // the half-bit point, DATA and STOP count full bit periods.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clock_count <= '0;
            bit_idx     <= '0;
            rx_byte     <= '0;
            rx_dv       <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    clock_count <= '0;
                    bit_idx     <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clock_count != HALF) begin
                        clock_count <= clock_count + 16'd1;
                    end else begin
                        clock_count <= '0;
                        // A line back high at the start-bit centre was a glitch.
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (clock_count < LAST) begin
                        clock_count <= clock_count + 16'd1;
                    end else begin
                        clock_count      <= '0;
                        rx_byte[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (clock_count < LAST) begin
                        clock_count <= clock_count + 16'd1;
                    end else begin
                        clock_count <= '0;
                        rx_dv       <= 1'b1;
                        frame_err   <= ~rx_s;
                        state       <= CLEANUP;
                    end
                end
                CLEANUP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sm_state = state;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - randomized self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;

    localparam int HIST = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx8 = 1'b1;
    logic rx87 = 1'b1;

    logic        rx_dv8, frame_err8, busy8;
    logic [7:0]  rx_byte8;
    logic [2:0]  sm_state8;
    logic [15:0] cc8;
    logic        rx_dv87, frame_err87, busy87;
    logic [7:0]  rx_byte87;
    logic [2:0]  sm_state87;
    logic [15:0] cc87;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       line8 [HIST];
    logic       line87[HIST];
    logic [2:0] st8   [HIST];
    logic       bsy8  [HIST];

    int         a8_cyc[$];
    logic [7:0] a8_byte[$];
    logic       a8_err[$];
    int         a87_cyc[$];
    logic [7:0] a87_byte[$];
    logic       a87_err[$];
    int         e_cyc[$];
    logic [7:0] e_byte[$];
    logic       e_err[$];
    int         max_cc87 = 0;

    uart_rx_fsm #(.CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .rst(rst), .rx_serial(rx8), .rx_dv(rx_dv8), .rx_byte(rx_byte8),
        .frame_err(frame_err8), .sm_state(sm_state8), .clock_count(cc8), .busy(busy8)
    );

    uart_rx_fsm #(.CLKS_PER_BIT(87)) dut87 (
        .clk(clk), .rst(rst), .rx_serial(rx87), .rx_dv(rx_dv87), .rx_byte(rx_byte87),
        .frame_err(frame_err87), .sm_state(sm_state87), .clock_count(cc87), .busy(busy87)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log taken mid-cycle: line level, state, busy and completed frames.
    always @(negedge clk) begin
        if (cyc < HIST) begin
            line8[cyc]  = rx8;
            line87[cyc] = rx87;
            st8[cyc]    = sm_state8;
            bsy8[cyc]   = busy8;
        end
        if (!rst && rx_dv8) begin
            a8_cyc.push_back(cyc);
            a8_byte.push_back(rx_byte8);
            a8_err.push_back(frame_err8);
        end
        if (!rst && rx_dv87) begin
            a87_cyc.push_back(cyc);
            a87_byte.push_back(rx_byte87);
            a87_err.push_back(frame_err87);
        end
        if (!rst && int'(cc87) > max_cc87) max_cc87 = int'(cc87);
    end

    // Synchronised line as the receiver sees it: two cycles behind the pin.
    function automatic logic rxs(input int which, input int c);
        return (which != 0) ? line87[c - 2] : line8[c - 2];
    endfunction

    // Reference receiver: scan for a low line while idle, confirm at the start-bit
    // centre, sample each bit centre, report the frame after the stop-bit centre.
    task automatic predict(input int which, input int cpb, input int s, input int lim);
        int c;
        int half;
        logic [7:0] b;
        logic stop;
        half = (cpb - 1) / 2;
        c = s;
        e_cyc.delete();
        e_byte.delete();
        e_err.delete();
        while (c <= lim) begin
            if (rxs(which, c) == 1'b0) begin
                if (rxs(which, c + half + 1) == 1'b1) begin
                    c = c + half + 2;
                end else begin
                    for (int i = 0; i < 8; i++) b[i] = rxs(which, c + half + 1 + (i + 1) * cpb);
                    stop = rxs(which, c + half + 1 + 9 * cpb);
                    e_cyc.push_back(c + half + 2 + 9 * cpb);
                    e_byte.push_back(b);
                    e_err.push_back(~stop);
                    c = c + half + 3 + 9 * cpb;
                end
            end else begin
                c = c + 1;
            end
        end
    endtask

    task automatic clear_logs();
        a8_cyc.delete();
        a8_byte.delete();
        a8_err.delete();
        a87_cyc.delete();
        a87_byte.delete();
        a87_err.delete();
    endtask

    // Drives the first nbits of an 8N1 frame (start, data LSB first, stop).
    task automatic send(input int which, input logic [7:0] b, input logic stop,
                        input int nbits, output int start_cyc);
        logic [9:0] f;
        int cpb;
        f = {stop, b, 1'b0};
        cpb = (which != 0) ? 87 : 8;
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            if (which != 0) rx87 = f[i];
            else rx8 = f[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int which, input int n);
        if (which != 0) rx87 = 1'b1;
        else rx8 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (sm_state8 !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", sm_state8); end
        checks++; if (cc8 !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cc8); end
        checks++; if ({rx_dv8, frame_err8, busy8} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rx_dv8, frame_err8, busy8}); end
        checks++; if (rx_byte8 !== 8'h00) begin errors++; $display("FAIL reset_byte got %02h exp 00", rx_byte8); end
        checks++; if (sm_state87 !== 3'd0 || busy87 !== 1'b0) begin errors++; $display("FAIL reset_87 got state %0d busy %b exp 0 0", sm_state87, busy87); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(0, 4);
    endtask

    task automatic test_glitch();
        int s;
        int saw_data;
        clear_logs();
        s = cyc;
        rx8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(0, 30);
        saw_data = 0;
        for (int c = s; c < cyc; c++) if (st8[c] == 3'd2) saw_data = 1;
        checks++; if (st8[s + 3] !== 3'd1) begin errors++; $display("FAIL glitch_start got %0d exp 1", st8[s + 3]); end
        checks++; if (st8[s + 7] !== 3'd0) begin errors++; $display("FAIL glitch_idle got %0d exp 0", st8[s + 7]); end
        checks++; if (saw_data != 0) begin errors++; $display("FAIL glitch_data got %0d exp 0", saw_data); end
        checks++; if (a8_cyc.size() != 0) begin errors++; $display("FAIL glitch_dv got %0d exp 0", a8_cyc.size()); end
        checks++; if (rx_byte8 !== 8'h00) begin errors++; $display("FAIL glitch_byte got %02h exp 00", rx_byte8); end
    endtask

    task automatic test_single();
        int n;
        int d;
        clear_logs();
        send(0, 8'hA5, 1'b1, 10, n);
        idle(0, 20);
        checks++; if (a8_cyc.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", a8_cyc.size()); end
        if (a8_cyc.size() >= 1) begin
            d = a8_cyc[0];
            checks++; if (d - n !== 79) begin errors++; $display("FAIL single_latency got %0d exp 79", d - n); end
            checks++; if (a8_byte[0] !== 8'hA5) begin errors++; $display("FAIL single_byte got %02h exp a5", a8_byte[0]); end
            checks++; if (a8_err[0] !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", a8_err[0]); end
            checks++; if (st8[d] !== 3'd4) begin errors++; $display("FAIL single_cleanup got %0d exp 4", st8[d]); end
            checks++; if (bsy8[d] !== 1'b1 || bsy8[d + 1] !== 1'b0) begin errors++; $display("FAIL single_busy got %b%b exp 10", bsy8[d], bsy8[d + 1]); end
        end
        checks++; if (rx_byte8 !== 8'hA5) begin errors++; $display("FAIL single_hold got %02h exp a5", rx_byte8); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int n1;
        clear_logs();
        send(0, 8'h00, 1'b1, 10, n0);
        send(0, 8'hFF, 1'b1, 10, n1);
        idle(0, 20);
        checks++; if (a8_cyc.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", a8_cyc.size()); end
        if (a8_cyc.size() >= 2) begin
            checks++; if (a8_cyc[1] - a8_cyc[0] !== 80) begin errors++; $display("FAIL b2b_gap got %0d exp 80", a8_cyc[1] - a8_cyc[0]); end
            checks++; if (a8_byte[0] !== 8'h00 || a8_byte[1] !== 8'hFF) begin errors++; $display("FAIL b2b_bytes got %02h %02h exp 00 ff", a8_byte[0], a8_byte[1]); end
            checks++; if (a8_err[0] !== 1'b0 || a8_err[1] !== 1'b0) begin errors++; $display("FAIL b2b_err got %b%b exp 00", a8_err[0], a8_err[1]); end
        end
    endtask

    task automatic test_stop_err_break();
        int n;
        int brk;
        clear_logs();
        send(0, 8'h3C, 1'b0, 10, n);
        idle(0, 20);
        rx8 = 1'b0;
        repeat (240) @(posedge clk);
        #1;
        idle(0, 120);
        predict(0, 8, n, cyc - 90);
        checks++; if (a8_cyc.size() != e_cyc.size()) begin errors++; $display("FAIL break_count got %0d exp %0d", a8_cyc.size(), e_cyc.size()); end
        for (int i = 0; i < e_cyc.size() && i < a8_cyc.size(); i++) begin
            checks++;
            if (a8_cyc[i] !== e_cyc[i] || a8_byte[i] !== e_byte[i] || a8_err[i] !== e_err[i]) begin
                errors++;
                $display("FAIL break_frame%0d got cyc %0d byte %02h err %b exp cyc %0d byte %02h err %b",
                         i, a8_cyc[i], a8_byte[i], a8_err[i], e_cyc[i], e_byte[i], e_err[i]);
            end
        end
        if (a8_cyc.size() >= 1) begin
            checks++; if (a8_byte[0] !== 8'h3C || a8_err[0] !== 1'b1) begin errors++; $display("FAIL stoplow got %02h err %b exp 3c err 1", a8_byte[0], a8_err[0]); end
        end
        brk = 0;
        for (int i = 1; i < a8_cyc.size(); i++) if (a8_byte[i] == 8'h00 && a8_err[i] == 1'b1) brk++;
        checks++; if (brk != 3) begin errors++; $display("FAIL break_zero_frames got %0d exp 3", brk); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        send(0, 8'h5A, 1'b1, 5, n);
        checks++; if (sm_state8 !== 3'd2) begin errors++; $display("FAIL mid_in_data got %0d exp 2", sm_state8); end
        rst = 1'b1;
        #1;
        checks++; if (sm_state8 !== 3'd0 || cc8 !== 16'd0 || busy8 !== 1'b0) begin errors++; $display("FAIL mid_async got state %0d count %0d busy %b exp 0 0 0", sm_state8, cc8, busy8); end
        checks++; if (rx_byte8 !== 8'h00 || rx_dv8 !== 1'b0 || frame_err8 !== 1'b0) begin errors++; $display("FAIL mid_outputs got %02h %b %b exp 00 0 0", rx_byte8, rx_dv8, frame_err8); end
        rx8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(0, 100);
        checks++; if (a8_cyc.size() != 0) begin errors++; $display("FAIL mid_partial_dv got %0d exp 0", a8_cyc.size()); end
        clear_logs();
        send(0, 8'h5A, 1'b1, 10, n);
        idle(0, 20);
        checks++; if (a8_cyc.size() != 1) begin errors++; $display("FAIL mid_after_count got %0d exp 1", a8_cyc.size()); end
        if (a8_cyc.size() >= 1) begin
            checks++; if (a8_byte[0] !== 8'h5A || a8_err[0] !== 1'b0 || a8_cyc[0] - n !== 79) begin errors++; $display("FAIL mid_after got %02h err %b lat %0d exp 5a err 0 lat 79", a8_byte[0], a8_err[0], a8_cyc[0] - n); end
        end
    endtask

    task automatic test_default_87();
        int n;
        clear_logs();
        max_cc87 = 0;
        send(1, 8'h81, 1'b1, 10, n);
        idle(1, 100);
        checks++; if (a87_cyc.size() != 1) begin errors++; $display("FAIL d87_count got %0d exp 1", a87_cyc.size()); end
        if (a87_cyc.size() >= 1) begin
            checks++; if (a87_cyc[0] - n !== 830) begin errors++; $display("FAIL d87_latency got %0d exp 830", a87_cyc[0] - n); end
            checks++; if (a87_byte[0] !== 8'h81 || a87_err[0] !== 1'b0) begin errors++; $display("FAIL d87_byte got %02h err %b exp 81 err 0", a87_byte[0], a87_err[0]); end
        end
        checks++; if (max_cc87 != 86) begin errors++; $display("FAIL d87_maxcount got %0d exp 86", max_cc87); end
    endtask

    task automatic test_random();
        int n;
        int s;
        logic [7:0] b;
        logic stop;
        clear_logs();
        s = cyc;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send(0, b, stop, 10, n);
            idle(0, $urandom_range(0, 12));
        end
        idle(0, 100);
        predict(0, 8, s, cyc - 90);
        checks++; if (a8_cyc.size() != e_cyc.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", a8_cyc.size(), e_cyc.size()); end
        for (int i = 0; i < e_cyc.size() && i < a8_cyc.size(); i++) begin
            checks++;
            if (a8_cyc[i] !== e_cyc[i] || a8_byte[i] !== e_byte[i] || a8_err[i] !== e_err[i]) begin
                errors++;
                $display("FAIL rand_frame%0d got cyc %0d byte %02h err %b exp cyc %0d byte %02h err %b",
                         i, a8_cyc[i], a8_byte[i], a8_err[i], e_cyc[i], e_byte[i], e_err[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_back_to_back();
        test_stop_err_break();
        test_reset_mid();
        test_default_87();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
